// File: rtl/maze_stim_checker_if.sv
// Serial maze link between the stimulus/check block and the maze solver.
//   maze, in_valid         : bit-serial maze stream towards the solver
//   out_valid              : qualifies one response cycle from the solver
//   maze_not_valid         : solver reports "no path" on its first valid cycle
//   out_x, out_y           : one path coordinate (column, row) per valid cycle
// master = stimulus/check side, slave = solver side.
interface maze_stim_checker_if;
  logic       maze;
  logic       in_valid;
  logic       out_valid;
  logic       maze_not_valid;
  logic [3:0] out_x;
  logic [3:0] out_y;

  modport master (
    output maze, in_valid,
    input  out_valid, maze_not_valid, out_x, out_y
  );

  modport slave (
    input  maze, in_valid,
    output out_valid, maze_not_valid, out_x, out_y
  );
endinterface

// File: rtl/maze_stim_checker.sv
// Stimulus-and-check end of the serial maze link. Holds a 15x15 maze written
// row by row, streams it bit-serially to the solver (row 0 col 0 first), then
// captures the solver's coordinate stream and grades it.
// Ports:
//   clk, rst_n             : clock, asynchronous active-low reset
//   load_en/load_row/data  : write one maze row (bit c = column c, 1 = wall)
//   start, expect_path     : launch a run; expect_path sampled with start
//   bus (master)           : serial maze out, solver response in
//   busy                   : run in progress (SEND, WAIT, CHECK)
//   done                   : one-cycle pulse at end of run
//   pass, resp_no_path     : result of the last run
//   path_len, err_code     : coordinate count and first error of last run
//
// state  | meaning
// IDLE   | waiting for start, maze rows may be loaded
// SEND   | streaming the 225 maze bits
// WAIT   | waiting for the first response cycle, timeout running
// CHECK  | consuming response cycles until out_valid falls
// DONE   | one cycle, results final; start may relaunch directly
module maze_stim_checker #(
  parameter int TIMEOUT  = 4095,
  parameter int PATH_MAX = 225
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load_en,
  input  logic [3:0]          load_row,
  input  logic [14:0]         load_data,
  input  logic                start,
  input  logic                expect_path,
  maze_stim_checker_if.master bus,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic                resp_no_path,
  output logic [7:0]          path_len,
  output logic [2:0]          err_code
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SEND  = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_CHECK = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // DONE is registered, so the decision is taken one cycle early; DONE then
  // lands exactly TIMEOUT cycles after the last in_valid cycle.
  localparam logic [11:0] TO_LAST = 12'(TIMEOUT - 2);
  localparam logic [7:0]  LEN_MAX = 8'(PATH_MAX);

  logic [2:0]  state;
  logic [14:0] mem [15];
  logic [3:0]  row, col;
  logic [11:0] wait_cnt;
  logic        exp_q;
  logic        first13;
  logic [3:0]  prev_x, prev_y;
  logic        maze_q, in_valid_q;

  logic        idle_like, load_ok, first_bit;
  logic [3:0]  nxt_row, nxt_col;
  logic        nxt_bit;
  logic        coord_take, first_coord, start_ok, adjacent, wall;
  logic [2:0]  coord_err;
  logic        end_ok;
  logic [2:0]  final_err;

  assign bus.maze     = maze_q;
  assign bus.in_valid = in_valid_q;
  assign busy = (state == ST_SEND) || (state == ST_WAIT) || (state == ST_CHECK);

  assign idle_like = (state == ST_IDLE) || (state == ST_DONE);
  assign load_ok   = idle_like && load_en && (load_row != 4'd15);
  // A row written in the start cycle must already be visible in bit 0.
  assign first_bit = (load_ok && load_row == 4'd0) ? load_data[0] : mem[0][0];

  function automatic logic step1(input logic [3:0] a, input logic [3:0] b);
    return ({1'b0, a} == {1'b0, b} + 5'd1) || ({1'b0, b} == {1'b0, a} + 5'd1);
  endfunction

  always_comb begin
    nxt_row = row;
    nxt_col = col + 4'd1;
    if (col == 4'd14) begin
      nxt_col = 4'd0;
      nxt_row = row + 4'd1;
    end
    nxt_bit = (nxt_row == 4'd15) ? 1'b0 : mem[nxt_row][nxt_col];
  end

  always_comb begin
    coord_take  = bus.out_valid &&
                  (((state == ST_WAIT) && !bus.maze_not_valid) ||
                   ((state == ST_CHECK) && !resp_no_path));
    first_coord = (path_len == 8'd0);
    start_ok    = ((bus.out_x == 4'd13) && (bus.out_y == 4'd13)) ||
                  ((bus.out_x == 4'd1) && (bus.out_y == 4'd1));
    adjacent    = ((bus.out_x == prev_x) && step1(bus.out_y, prev_y)) ||
                  ((bus.out_y == prev_y) && step1(bus.out_x, prev_x));
    // Coordinates off the 15x15 grid count as walls.
    if ((bus.out_x == 4'd15) || (bus.out_y == 4'd15)) wall = 1'b1;
    else                                              wall = mem[bus.out_y][bus.out_x];
    coord_err = 3'd0;
    if (first_coord && !start_ok)       coord_err = 3'd2;
    else if (!first_coord && !adjacent) coord_err = 3'd3;
    else if (wall)                      coord_err = 3'd4;
    else if (path_len == LEN_MAX)       coord_err = 3'd6;
  end

  always_comb begin
    end_ok = first13 ? ((prev_x == 4'd1) && (prev_y == 4'd1))
                     : ((prev_x == 4'd13) && (prev_y == 4'd13));
    final_err = err_code;
    if (err_code == 3'd0) begin
      if (!resp_no_path && !end_ok)    final_err = 3'd5;
      else if (resp_no_path == exp_q)  final_err = 3'd7;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      mem          <= '{default: '0};
      row          <= '0;
      col          <= '0;
      wait_cnt     <= '0;
      exp_q        <= 1'b0;
      first13      <= 1'b0;
      prev_x       <= '0;
      prev_y       <= '0;
      maze_q       <= 1'b0;
      in_valid_q   <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      resp_no_path <= 1'b0;
      path_len     <= '0;
      err_code     <= '0;
    end else begin
      done <= 1'b0;
      if (load_ok) mem[load_row] <= load_data;

      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state        <= ST_SEND;
            row          <= '0;
            col          <= '0;
            in_valid_q   <= 1'b1;
            maze_q       <= first_bit;
            exp_q        <= expect_path;
            pass         <= 1'b0;
            resp_no_path <= 1'b0;
            path_len     <= '0;
            err_code     <= '0;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_SEND: begin
          if ((row == 4'd14) && (col == 4'd14)) begin
            in_valid_q <= 1'b0;
            maze_q     <= 1'b0;
            wait_cnt   <= '0;
            state      <= ST_WAIT;
          end else begin
            row    <= nxt_row;
            col    <= nxt_col;
            maze_q <= nxt_bit;
          end
        end
        ST_WAIT: begin
          if (bus.out_valid) begin
            state <= ST_CHECK;
            if (bus.maze_not_valid) resp_no_path <= 1'b1;
          end else if (wait_cnt == TO_LAST) begin
            err_code <= 3'd1;
            pass     <= 1'b0;
            done     <= 1'b1;
            state    <= ST_DONE;
          end else begin
            wait_cnt <= wait_cnt + 12'd1;
          end
        end
        ST_CHECK: begin
          if (!bus.out_valid) begin
            err_code <= final_err;
            pass     <= (final_err == 3'd0);
            done     <= 1'b1;
            state    <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (coord_take) begin
        if (err_code == 3'd0) err_code <= coord_err;
        if (path_len != LEN_MAX) path_len <= path_len + 8'd1;
        prev_x <= bus.out_x;
        prev_y <= bus.out_y;
        if (first_coord) first13 <= (bus.out_x == 4'd13);
      end
    end
  end

endmodule

// File: tb/tb_maze_stim_checker.sv
// Bench for maze_stim_checker: acts as the solver, checks the serial maze
// stream against a row/column array model and grades results with a model
// built directly from the path rules.
module tb_maze_stim_checker;
  localparam int TO = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_en = 1'b0;
  logic [3:0]  load_row = '0;
  logic [14:0] load_data = '0;
  logic        start = 1'b0;
  logic        expect_path = 1'b0;
  logic        busy, done, pass, resp_no_path;
  logic [7:0]  path_len;
  logic [2:0]  err_code;

  maze_stim_checker_if bus ();

  maze_stim_checker #(.TIMEOUT(TO), .PATH_MAX(225)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_en     (load_en),
    .load_row    (load_row),
    .load_data   (load_data),
    .start       (start),
    .expect_path (expect_path),
    .bus         (bus.master),
    .busy        (busy),
    .done        (done),
    .pass        (pass),
    .resp_no_path(resp_no_path),
    .path_len    (path_len),
    .err_code    (err_code)
  );

  always #5 clk = ~clk;

  int        n_checks = 0;
  int        n_errors = 0;
  bit [14:0] model [15];
  int        qx[$], qy[$];
  bit        cap [225];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic load(input int r, input bit [14:0] d);
    @(negedge clk);
    load_en = 1'b1; load_row = 4'(r); load_data = d;
    @(negedge clk);
    load_en = 1'b0;
    if (r < 15) model[r] = d;
  endtask

  // Expected outcome from the grading rules: mode 0 path, 1 no-path, 2 silent.
  task automatic expect_result(input bit e, input int mode, output int xerr, output int xlen, output int xnp);
    int n, c, ex;
    xerr = 0; xlen = 0; xnp = 0;
    if (mode == 2) begin
      xerr = 1;
    end else if (mode == 1) begin
      xnp = 1;
      xerr = e ? 7 : 0;
    end else begin
      n = qx.size();
      xlen = (n > 225) ? 225 : n;
      for (int i = 0; i < n; i++) begin
        c = 0;
        if (i == 0 && !((qx[0] == 13 && qy[0] == 13) || (qx[0] == 1 && qy[0] == 1))) c = 2;
        else if (i > 0 && (iabs(qx[i] - qx[i-1]) + iabs(qy[i] - qy[i-1]) != 1)) c = 3;
        else if (qx[i] > 14 || qy[i] > 14) c = 4;
        else if (model[qy[i]][qx[i]]) c = 4;
        else if (i >= 225) c = 6;
        if (xerr == 0) xerr = c;
      end
      if (xerr == 0) begin
        ex = (qx[0] == 13) ? 1 : 13;
        if (qx[n-1] != ex || qy[n-1] != ex) xerr = 5;
      end
      if (xerr == 0 && !e) xerr = 7;
    end
  endtask

  task automatic do_run(input bit e, input int mode, input int delay, input bit ld_same,
                        input int ld_r, input bit [14:0] ld_d, input bit disturb, input bit b2b);
    int nv, nmis, w, xerr, xlen, xnp;
    if (!b2b) @(negedge clk);
    start = 1'b1; expect_path = e;
    if (ld_same) begin
      load_en = 1'b1; load_row = 4'(ld_r); load_data = ld_d;
      if (ld_r < 15) model[ld_r] = ld_d;
    end
    @(negedge clk);
    start = 1'b0; load_en = 1'b0;
    check("done_single", done, 0);
    check("err_cleared", err_code, 0);
    check("pass_cleared", pass, 0);
    check("len_cleared", path_len, 0);
    check("busy_send", busy, 1);
    check("in_valid_first", bus.in_valid, 1);
    nv = 0; nmis = 0;
    while (bus.in_valid === 1'b1 && nv < 300) begin
      if (nv < 225) begin
        cap[nv] = bus.maze;
        if (bus.maze !== model[nv / 15][nv % 15]) nmis++;
      end
      if (disturb && nv == 60) begin
        start = 1'b1; load_en = 1'b1; load_row = 4'd3; load_data = '1;
        bus.out_valid = 1'b1; bus.maze_not_valid = 1'b1;
      end else if (disturb && nv == 61) begin
        start = 1'b0; load_en = 1'b0; bus.out_valid = 1'b0; bus.maze_not_valid = 1'b0;
      end
      nv++;
      @(negedge clk);
    end
    check("in_valid_len", nv, 225);
    check("stream_bits", nmis, 0);
    check("maze_idle_zero", bus.maze, 0);
    expect_result(e, mode, xerr, xlen, xnp);
    if (mode == 2) begin
      w = 1;
      while (done !== 1'b1 && w < 100) begin @(negedge clk); w++; end
      check("timeout_cycles", w, TO);
    end else begin
      repeat (delay) @(negedge clk);
      if (mode == 1) begin
        bus.out_valid = 1'b1; bus.maze_not_valid = 1'b1;
        bus.out_x = 4'($urandom); bus.out_y = 4'($urandom);
        @(negedge clk);
        repeat ($urandom_range(0, 2)) begin
          bus.maze_not_valid = 1'($urandom); bus.out_x = 4'($urandom);
          @(negedge clk);
        end
      end else begin
        for (int i = 0; i < qx.size(); i++) begin
          bus.out_valid = 1'b1; bus.maze_not_valid = 1'b0;
          bus.out_x = 4'(qx[i]); bus.out_y = 4'(qy[i]);
          @(negedge clk);
        end
      end
      bus.out_valid = 1'b0; bus.maze_not_valid = 1'b0;
      w = 0;
      while (done !== 1'b1 && w < 10) begin @(negedge clk); w++; end
      check("done_latency", w, 1);
    end
    check("err_code", err_code, xerr);
    check("pass", pass, (xerr == 0));
    check("path_len", path_len, xlen);
    check("resp_no_path", resp_no_path, xnp);
    check("busy_done", busy, 0);
  endtask

  task automatic build_path_a(input bit rev);
    qx.delete(); qy.delete();
    for (int y = 13; y >= 1; y--) begin qx.push_back(13); qy.push_back(y); end
    for (int x = 12; x >= 1; x--) begin qx.push_back(x); qy.push_back(1); end
    if (rev) begin qx.reverse(); qy.reverse(); end
  endtask

  task automatic gen_walk();
    int x, y, n, d;
    if ($urandom_range(0, 3) == 0) begin
      build_path_a(1'($urandom));
      return;
    end
    qx.delete(); qy.delete();
    d = $urandom_range(0, 9);
    if (d < 7)      begin x = 13; y = 13; end
    else if (d < 9) begin x = 1;  y = 1;  end
    else            begin x = $urandom_range(0, 15); y = $urandom_range(0, 15); end
    qx.push_back(x); qy.push_back(y);
    n = $urandom_range(0, 30);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        x = $urandom_range(0, 15); y = $urandom_range(0, 15);
      end else begin
        d = $urandom_range(0, 3);
        case (d)
          0: x = (x >= 14) ? x - 1 : x + 1;
          1: x = (x == 0)  ? 1     : x - 1;
          2: y = (y >= 14) ? y - 1 : y + 1;
          default: y = (y == 0) ? 1 : y - 1;
        endcase
      end
      qx.push_back(x); qy.push_back(y);
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int mode;
    bus.out_valid = 1'b0; bus.maze_not_valid = 1'b0; bus.out_x = '0; bus.out_y = '0;
    foreach (model[r]) model[r] = '0;
    repeat (3) @(negedge clk);
    check("rst_in_valid", bus.in_valid, 0);
    check("rst_maze", bus.maze, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_no_path", resp_no_path, 0);
    check("rst_len", path_len, 0);
    check("rst_err", err_code, 0);
    rst_n = 1'b1;

    for (int r = 0; r < 15; r++) load(r, (r == 0 || r == 14) ? 15'h7fff : 15'h4001);

    build_path_a(1'b0);
    do_run(1'b1, 0, 3, 1'b0, 0, '0, 1'b0, 1'b0);
    check("bit0_wall", cap[0], 1);
    check("bit16_open", cap[16], 0);

    qx = '{13, 13}; qy = '{13, 11};
    do_run(1'b1, 0, 0, 1'b0, 0, '0, 1'b0, 1'b0);

    load(5, 15'h4081);
    qx.delete(); qy.delete();
    for (int y = 13; y >= 5; y--) begin qx.push_back(13); qy.push_back(y); end
    for (int x = 12; x >= 1; x--) begin qx.push_back(x); qy.push_back(5); end
    for (int y = 4; y >= 1; y--) begin qx.push_back(1); qy.push_back(y); end
    do_run(1'b1, 0, 2, 1'b0, 0, '0, 1'b0, 1'b0);

    do_run(1'b1, 1, 1, 1'b0, 0, '0, 1'b0, 1'b0);
    do_run(1'b0, 1, 4, 1'b0, 0, '0, 1'b0, 1'b1);
    do_run(1'b1, 2, 0, 1'b0, 0, '0, 1'b0, 1'b0);

    qx.delete(); qy.delete();
    for (int i = 0; i < 230; i++) begin qx.push_back(1); qy.push_back(1 + (i % 2)); end
    do_run(1'b1, 0, 0, 1'b0, 0, '0, 1'b0, 1'b0);

    build_path_a(1'b1);
    do_run(1'b0, 0, 5, 1'b0, 0, '0, 1'b1, 1'b0);
    build_path_a(1'b0);
    do_run(1'b1, 0, 0, 1'b0, 0, '0, 1'b0, 1'b1);

    do_run(1'b1, 1, 0, 1'b1, 0, 15'($urandom), 1'b0, 1'b0);

    @(negedge clk);
    start = 1'b1; expect_path = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (50) @(negedge clk);
    check("busy_mid_send", busy, 1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_in_valid", bus.in_valid, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_maze", bus.maze, 0);
    @(negedge clk);
    rst_n = 1'b1;
    foreach (model[r]) model[r] = '0;
    do_run(1'b1, 2, 0, 1'b0, 0, '0, 1'b0, 1'b0);

    for (int t = 0; t < 30; t++) begin
      if ($urandom_range(0, 2) == 0) load($urandom_range(0, 15), 15'($urandom & $urandom & $urandom));
      gen_walk();
      mode = $urandom_range(0, 99);
      mode = (mode < 10) ? 2 : (mode < 35) ? 1 : 0;
      do_run(1'($urandom), mode, $urandom_range(0, 10), 1'($urandom_range(0, 4) == 0),
             $urandom_range(0, 15), 15'($urandom), 1'b0, 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
